// File: rtl/id_regfile_mp.sv
// ID-stage integer register file: multi-port read/write with write-to-read bypass,
// per-register pending scoreboard and a sequential zeroing sweep instead of a reset loop.
module id_regfile_mp #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 2
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic [NUM_RD*ADDR_W-1:0] Rs_addr,
  output logic [NUM_RD*DATA_W-1:0] Rs_data,
  output logic [NUM_RD-1:0]        Rs_pending,
  input  logic [NUM_WR-1:0]        Wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] Wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] Wr_data,
  input  logic                     Issue_en,
  input  logic [ADDR_W-1:0]        Issue_addr,
  input  logic                     Flush,
  input  logic                     Init_req,
  output logic                     Ready
);

  typedef enum logic {StClear, StRun} state_e;

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DEPTH-1:0]  pending_q, pending_d;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [NUM_WR-1:0] wr_act;

  function automatic logic addr_ok(logic [ADDR_W-1:0] a);
    return (a != '0) && (32'(a) < DEPTH);
  endfunction

  always_comb begin
    wr_act = '0;
    for (int j = 0; j < int'(NUM_WR); j++) begin
      wr_act[j] = (state_q == StRun) && Wr_en[j] && addr_ok(Wr_addr[j*ADDR_W +: ADDR_W]);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    unique case (state_q)
      StClear: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastIdx) state_d = StRun;
      end
      StRun: begin
        if (Init_req) begin
          state_d   = StClear;
          cnt_d     = ADDR_W'(1);
          pending_d = '0;
        end else if (Flush) begin
          pending_d = '0;
        end else begin
          for (int j = 0; j < int'(NUM_WR); j++) begin
            if (wr_act[j]) pending_d[Wr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
          end
          // A newly issued producer supersedes a same-cycle retire of the older one.
          if (Issue_en && addr_ok(Issue_addr)) pending_d[Issue_addr] = 1'b1;
        end
      end
      default: ;
    endcase
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= StClear;
      cnt_q     <= ADDR_W'(1);
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  // Storage has no reset so it can map onto RAM; the sweep zeroes it instead.
  always_ff @(posedge Clk) begin
    if (state_q == StClear) regs_q[cnt_q] <= '0;
    for (int j = 0; j < int'(NUM_WR); j++) begin
      if (wr_act[j]) regs_q[Wr_addr[j*ADDR_W +: ADDR_W]] <= Wr_data[j*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    Rs_data    = '0;
    Rs_pending = '0;
    for (int i = 0; i < int'(NUM_RD); i++) begin
      logic [ADDR_W-1:0] rs;
      logic [DATA_W-1:0] rd;
      logic              hit;
      rs  = Rs_addr[i*ADDR_W +: ADDR_W];
      rd  = regs_q[rs];
      hit = 1'b0;
      for (int j = 0; j < int'(NUM_WR); j++) begin
        if (wr_act[j] && (Wr_addr[j*ADDR_W +: ADDR_W] == rs)) begin
          hit = 1'b1;
          rd  = Wr_data[j*DATA_W +: DATA_W];
        end
      end
      if ((state_q == StRun) && addr_ok(rs)) begin
        Rs_data[i*DATA_W +: DATA_W] = rd;
        Rs_pending[i]               = pending_q[rs] & ~hit;
      end
    end
  end

  assign Ready = (state_q == StRun);

endmodule
